// File: rtl/nap_timer.sv
// Nap countdown timer: preset in minutes, 1 Hz countdown, alarm start/stop pulses.
// Optional snooze in RING is enabled by defining NAP_TIMER_SNOOZE_EN.
module nap_timer #(
  parameter int DEFAULT_MIN = 20,
  parameter int MAX_MIN     = 90,
  parameter int RING_SEC    = 60,
  parameter int SNOOZE_MIN  = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       inc,
  input  logic       go,
  input  logic       cancel,
  input  logic       dismiss,
  input  logic       snooze,
  output logic       alarm_start,
  output logic       alarm_stop,
  output logic [6:0] rem_min,
  output logic [5:0] rem_sec,
  output logic [6:0] preset_min,
  output logic       running,
  output logic       ringing
);

  localparam int RCW = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
  localparam logic [6:0]     L_DEFAULT   = 7'(DEFAULT_MIN);
  localparam logic [6:0]     L_MAX       = 7'(MAX_MIN);
  localparam logic [RCW-1:0] L_RING_LAST = RCW'(RING_SEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, RING} state_t;

  state_t         r_state, w_state_nx;
  logic [6:0]     r_preset, w_preset_nx, w_preset_inc;
  logic [6:0]     r_rem_min, w_rem_min_nx;
  logic [5:0]     r_rem_sec, w_rem_sec_nx;
  logic [RCW-1:0] r_ring_cnt, w_ring_cnt_nx;
  logic           r_alarm_start, w_alarm_start_nx;
  logic           r_alarm_stop, w_alarm_stop_nx;
  logic           r_running, r_ringing;

`ifndef NAP_TIMER_SNOOZE_EN
  logic w_unused_snooze;
  assign w_unused_snooze = snooze;
`endif

  assign w_preset_inc = (r_preset >= L_MAX) ? 7'd1 : r_preset + 7'd1;

  always_comb begin
    // NOTE: every next-value gets a default first so no path can infer a latch.
    w_state_nx       = r_state;
    w_preset_nx      = r_preset;
    w_rem_min_nx     = r_rem_min;
    w_rem_sec_nx     = r_rem_sec;
    w_ring_cnt_nx    = r_ring_cnt;
    w_alarm_start_nx = 1'b0;
    w_alarm_stop_nx  = 1'b0;

    case (r_state)
      IDLE: begin
        if (go) begin
          w_state_nx   = RUN;
          w_rem_min_nx = r_preset;
          w_rem_sec_nx = 6'd0;
        end else if (inc) begin
          w_preset_nx  = w_preset_inc;
          w_rem_min_nx = w_preset_inc;
          w_rem_sec_nx = 6'd0;
        end
      end

      RUN: begin
        if (cancel) begin
          w_state_nx   = IDLE;
          w_rem_min_nx = r_preset;
          w_rem_sec_nx = 6'd0;
        end else if (go) begin
          w_state_nx = PAUSE;
        end else if (tick) begin
          // Ring on the tick that would reach 0:00, so rem never underflows.
          if (r_rem_min == 7'd0 && r_rem_sec <= 6'd1) begin
            w_state_nx       = RING;
            w_rem_sec_nx     = 6'd0;
            w_ring_cnt_nx    = '0;
            w_alarm_start_nx = 1'b1;
          end else if (r_rem_sec != 6'd0) begin
            w_rem_sec_nx = r_rem_sec - 6'd1;
          end else begin
            w_rem_min_nx = r_rem_min - 7'd1;
            w_rem_sec_nx = 6'd59;
          end
        end
      end

      PAUSE: begin
        if (cancel) begin
          w_state_nx   = IDLE;
          w_rem_min_nx = r_preset;
          w_rem_sec_nx = 6'd0;
        end else if (go) begin
          w_state_nx = RUN;
        end
      end

      RING: begin
        if (cancel || dismiss || (tick && r_ring_cnt == L_RING_LAST)) begin
          w_state_nx      = IDLE;
          w_rem_min_nx    = r_preset;
          w_rem_sec_nx    = 6'd0;
          w_alarm_stop_nx = 1'b1;
`ifdef NAP_TIMER_SNOOZE_EN
        end else if (snooze) begin
          w_state_nx      = RUN;
          w_rem_min_nx    = 7'(SNOOZE_MIN);
          w_rem_sec_nx    = 6'd0;
          w_alarm_stop_nx = 1'b1;
`endif
        end else if (tick) begin
          w_ring_cnt_nx = r_ring_cnt + 1'b1;
        end
      end

      default: w_state_nx = IDLE;
    endcase
  end

  // Status flags come from the next state so every output is a flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_preset      <= L_DEFAULT;
      r_rem_min     <= L_DEFAULT;
      r_rem_sec     <= 6'd0;
      r_ring_cnt    <= '0;
      r_alarm_start <= 1'b0;
      r_alarm_stop  <= 1'b0;
      r_running     <= 1'b0;
      r_ringing     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      r_state       <= w_state_nx;
      r_preset      <= w_preset_nx;
      r_rem_min     <= w_rem_min_nx;
      r_rem_sec     <= w_rem_sec_nx;
      r_ring_cnt    <= w_ring_cnt_nx;
      r_alarm_start <= w_alarm_start_nx;
      r_alarm_stop  <= w_alarm_stop_nx;
      r_running     <= (w_state_nx == RUN);
      r_ringing     <= (w_state_nx == RING);
    end
  end

  assign alarm_start = r_alarm_start;
  assign alarm_stop  = r_alarm_stop;
  assign rem_min     = r_rem_min;
  assign rem_sec     = r_rem_sec;
  assign preset_min  = r_preset;
  assign running     = r_running;
  assign ringing     = r_ringing;

endmodule

// File: tb/tb_nap_timer.sv
// Self-checking bench for nap_timer: directed scenarios then random pulses,
// compared against a model that keeps remaining time as a plain seconds count.
module tb_nap_timer;

  localparam int DEFAULT_MIN = 20;
  localparam int MAX_MIN     = 90;
  localparam int RING_SEC    = 3;
  localparam int SNOOZE_MIN  = 1;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_RING  = 3;

  logic       clock, reset;
  logic       tick, inc, go, cancel, dismiss, snooze;
  logic       alarm_start, alarm_stop, running, ringing;
  logic [6:0] rem_min, preset_min;
  logic [5:0] rem_sec;

  int n_checks = 0;
  int n_errors = 0;

  int m_mode, m_preset, m_left, m_ring;
  bit m_start, m_stop;

  nap_timer #(
    .DEFAULT_MIN(DEFAULT_MIN),
    .MAX_MIN    (MAX_MIN),
    .RING_SEC   (RING_SEC),
    .SNOOZE_MIN (SNOOZE_MIN)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .inc        (inc),
    .go         (go),
    .cancel     (cancel),
    .dismiss    (dismiss),
    .snooze     (snooze),
    .alarm_start(alarm_start),
    .alarm_stop (alarm_stop),
    .rem_min    (rem_min),
    .rem_sec    (rem_sec),
    .preset_min (preset_min),
    .running    (running),
    .ringing    (ringing)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_preset = DEFAULT_MIN;
    m_left   = DEFAULT_MIN * 60;
    m_ring   = 0;
    m_start  = 0;
    m_stop   = 0;
  endtask

  task automatic model_step(input bit t, input bit i, input bit g,
                            input bit c, input bit d, input bit s);
    m_start = 0;
    m_stop  = 0;
    case (m_mode)
      M_IDLE: begin
        if (g) m_mode = M_RUN;
        else if (i) m_preset = (m_preset % MAX_MIN) + 1;
        m_left = m_preset * 60;
      end
      M_RUN: begin
        if (c) begin
          m_mode = M_IDLE;
          m_left = m_preset * 60;
        end else if (g) begin
          m_mode = M_PAUSE;
        end else if (t) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_mode  = M_RING;
            m_ring  = 0;
            m_start = 1;
          end
        end
      end
      M_PAUSE: begin
        if (c) begin
          m_mode = M_IDLE;
          m_left = m_preset * 60;
        end else if (g) begin
          m_mode = M_RUN;
        end
      end
      default: begin
        if (c || d) begin
          m_mode = M_IDLE;
          m_left = m_preset * 60;
          m_stop = 1;
`ifdef NAP_TIMER_SNOOZE_EN
        end else if (s) begin
          m_mode = M_RUN;
          m_left = SNOOZE_MIN * 60;
          m_stop = 1;
`endif
        end else if (t) begin
          m_ring = m_ring + 1;
          if (m_ring == RING_SEC) begin
            m_mode = M_IDLE;
            m_left = m_preset * 60;
            m_stop = 1;
          end
        end
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rem_min"},     rem_min,     m_left / 60);
    check({tag, ".rem_sec"},     rem_sec,     m_left % 60);
    check({tag, ".preset_min"},  preset_min,  m_preset);
    check({tag, ".running"},     running,     (m_mode == M_RUN) ? 1 : 0);
    check({tag, ".ringing"},     ringing,     (m_mode == M_RING) ? 1 : 0);
    check({tag, ".alarm_start"}, alarm_start, m_start);
    check({tag, ".alarm_stop"},  alarm_stop,  m_stop);
  endtask

  // Called one time unit after a rising edge; drives one cycle of pulses.
  task automatic step(input string tag, input bit t, input bit i, input bit g,
                      input bit c, input bit d, input bit s);
    tick = t; inc = i; go = g; cancel = c; dismiss = d; snooze = s;
    @(posedge clock);
    #1;
    tick = 0; inc = 0; go = 0; cancel = 0; dismiss = 0; snooze = 0;
    model_step(t, i, g, c, d, s);
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0;
    tick = 0; inc = 0; go = 0; cancel = 0; dismiss = 0; snooze = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    #3 reset = 1'b1;
    @(posedge clock);
    #1;
    check_all("post_reset");

    // Preset stepping and wrap.
    repeat (3) step("inc", 0, 1, 0, 0, 0, 0);
    check("preset23", preset_min, 23);
    check("rem23", rem_min, 23);
    repeat (66) step("inc", 0, 1, 0, 0, 0, 0);
    check("preset89", preset_min, 89);
    step("inc90", 0, 1, 0, 0, 0, 0);
    check("preset90", preset_min, 90);
    step("inc_wrap", 0, 1, 0, 0, 0, 0);
    check("preset_wrap", preset_min, 1);

    // Full one-minute countdown into RING, then dismiss.
    step("go", 0, 0, 1, 0, 0, 0);
    check("go.running", running, 1);
    step("tick1", 1, 0, 0, 0, 0, 0);
    check("tick1.sec", rem_sec, 59);
    repeat (58) step("count", 1, 0, 0, 0, 0, 0);
    step("last_tick", 1, 0, 0, 0, 0, 0);
    check("ring.start", alarm_start, 1);
    step("ring_hold", 0, 0, 0, 0, 0, 0);
    check("ring.start_once", alarm_start, 0);
    step("dismiss", 0, 0, 0, 0, 1, 0);
    check("dismiss.stop", alarm_stop, 1);
    step("after_dismiss", 0, 0, 0, 0, 0, 0);

    // Pause/resume at 0:45, go+tick collision, cancel+go at 0:10.
    step("go2", 0, 0, 1, 0, 0, 0);
    repeat (15) step("to45", 1, 0, 0, 0, 0, 0);
    check("at45", rem_sec, 45);
    step("pause", 0, 0, 1, 0, 0, 0);
    repeat (5) step("paused_tick", 1, 0, 0, 0, 0, 0);
    check("paused45", rem_sec, 45);
    step("resume", 0, 0, 1, 0, 0, 0);
    step("tick44", 1, 0, 0, 0, 0, 0);
    check("at44", rem_sec, 44);
    step("go_tick", 1, 0, 1, 0, 0, 0);
    check("go_tick.sec", rem_sec, 44);
    step("resume2", 0, 0, 1, 0, 0, 0);
    repeat (34) step("to10", 1, 0, 0, 0, 0, 0);
    step("cancel_go", 0, 0, 1, 1, 0, 0);
    check("cancel.running", running, 0);

    // Auto-stop after RING_SEC ticks.
    step("go3", 0, 0, 1, 0, 0, 0);
    repeat (60) step("to_ring", 1, 0, 0, 0, 0, 0);
    repeat (RING_SEC - 1) step("ring_tick", 1, 0, 0, 0, 0, 0);
    check("ring_pre_stop", alarm_stop, 0);
    step("ring_last", 1, 0, 0, 0, 0, 0);
    check("auto_stop", alarm_stop, 1);

    // Snooze in RING.
    step("go4", 0, 0, 1, 0, 0, 0);
    repeat (60) step("to_ring2", 1, 0, 0, 0, 0, 0);
    step("snooze", 0, 0, 0, 0, 0, 1);
`ifdef NAP_TIMER_SNOOZE_EN
    check("snooze.running", running, 1);
    repeat (60) step("snooze_count", 1, 0, 0, 0, 0, 0);
    check("snooze.restart", alarm_start, 1);
`else
    check("snooze.ignored", ringing, 1);
`endif
    step("cancel_ring", 0, 0, 0, 1, 0, 0);

    // Asynchronous reset in the middle of RING.
    step("go5", 0, 0, 1, 0, 0, 0);
    repeat (60) step("to_ring3", 1, 0, 0, 0, 0, 0);
    #3 reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    check_all("after_rst");

    // Random pulse traffic.
    for (int n = 0; n < 4000; n++) begin
      step("rand",
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 149) == 0),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 29) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nap_timer.md
Name: nap_timer

Overview:
- Countdown stage directly upstream of the alarm sequencer.
- User sets a nap length in minutes and presses go. The block counts down on a 1 Hz tick enable.
- At zero it pulses alarm_start into the alarm sequencer, then drives alarm_stop when the user dismisses the alarm or the ring time expires.
- Remaining time is exported for the display stage.

Parameters:
DEFAULT_MIN, 20, preset minutes loaded at reset
MAX_MIN, 90, largest selectable preset; presets wrap MAX_MIN -> 1
RING_SEC, 60, ticks spent ringing before auto-stop
SNOOZE_MIN, 5, reload minutes on snooze (SNOOZE_EN only)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
tick  in  1  one-cycle 1 Hz enable pulse
inc  in  1  one-cycle pulse; preset_min+1
go  in  1  one-cycle pulse; start, pause or resume
cancel  in  1  one-cycle pulse; abort the countdown
dismiss  in  1  one-cycle pulse; user stops the ringing alarm
snooze  in  1  one-cycle pulse; used only with SNOOZE_EN
alarm_start  out  1  one-cycle pulse to the alarm sequencer start input
alarm_stop  out  1  one-cycle pulse to the alarm sequencer stop input
rem_min  out  7  remaining minutes, binary 0..MAX_MIN
rem_sec  out  6  remaining seconds, binary 0..59
preset_min  out  7  current preset, 1..MAX_MIN
running  out  1  high in RUN
ringing  out  1  high in RING

Behaviour:
- Reset (reset low, async) values:
  - state=IDLE, preset_min=DEFAULT_MIN.
  - rem_min=DEFAULT_MIN, rem_sec=0, ring counter=0.
  - All pulse and status outputs 0.
- All outputs are registered. Pulses are high for exactly one clock.
- States: IDLE, RUN, PAUSE, RING.
- IDLE:
  - inc: preset_min+1; MAX_MIN wraps to 1. rem_min tracks preset_min; rem_sec=0.
  - go: load rem_min=preset_min, rem_sec=0, enter RUN.
  - tick, cancel, dismiss: ignored.
- RUN:
  - On tick: if rem_sec>0, rem_sec-1. Else rem_min-1 and rem_sec=59.
  - Tick with rem=0:01: next cycle rem=0:00, state=RING, alarm_start=1, ring counter cleared.
  - go: enter PAUSE.
  - cancel: enter IDLE and reload rem from preset.
  - inc: ignored.
- PAUSE:
  - Counter frozen; ticks ignored.
  - go: return to RUN.
  - cancel: enter IDLE.
- RING:
  - rem held at 0:00.
  - Each tick increments the ring counter.
  - dismiss, cancel, or ring counter reaching RING_SEC: alarm_stop=1 next cycle, enter IDLE, reload rem from preset.
- Priority, same cycle: cancel > dismiss > go > tick > inc.
  - go and tick together in RUN: pause wins; the tick is lost.
- Latency: input pulse to state/output change is 1 clock.
- Reset mid-RUN or mid-RING returns to IDLE immediately, with no alarm_stop pulse. The downstream alarm sequencer shares the reset.
- preset_min changes only in IDLE.
- rem_min never underflows. RING is entered before 0:00 would decrement.

Optional Feature:
- Macro: NAP_TIMER_SNOOZE_EN.
- Defined:
  - In RING, snooze (below dismiss and cancel in priority) pulses alarm_stop.
  - It loads rem_min=SNOOZE_MIN, rem_sec=0, and enters RUN.
  - The next countdown to zero re-issues alarm_start.
- Undefined:
  - snooze port present but ignored in every state.
  - No snooze logic synthesized.

Test Plan:
- Reset, then inc x3 with MAX_MIN=90, DEFAULT_MIN=20 -> preset_min=23, rem=23:00, all pulses 0.
- preset 89, inc x2 -> preset_min 90 then 1; go -> running=1, rem=1:00; tick -> 0:59; 59 more ticks -> ringing=1, alarm_start high exactly 1 cycle, rem=0:00.
- RUN at 0:45: go -> PAUSE; 5 ticks -> rem stays 0:45; go, then 1 tick -> 0:44. Same cycle go+tick in RUN -> PAUSE, rem unchanged.
- RING: dismiss -> alarm_stop 1 cycle, IDLE, rem=preset:00. Separately, no dismiss with RING_SEC=3 -> alarm_stop after the 3rd tick.
- RUN at 0:10: cancel and go same cycle -> IDLE, no alarm pulse. Reset low mid-RING -> immediate IDLE, outputs at reset values.
- With NAP_TIMER_SNOOZE_EN, SNOOZE_MIN=1: snooze in RING -> alarm_stop pulse, RUN, rem=1:00; 60 ticks -> second alarm_start. Without the macro: snooze in RING -> no change.
